// File: rtl/ipd_sequencer_pkg.sv
// Shared types and constants for the I-PD sample sequencer.
// State encodings, default word width and saturation limits.
package ipd_sequencer_pkg;

    localparam int IPD_N = 18;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_TICK = 4'd1,
        ST_ADC_REQ   = 4'd2,
        ST_ADC_WAIT  = 4'd3,
        ST_CAPTURE   = 4'd4,
        ST_PIPE1     = 4'd5,
        ST_PIPE2     = 4'd6,
        ST_ACCUM     = 4'd7,
        ST_DONE      = 4'd8
    } ipd_state_t;

    function automatic logic signed [63:0] sat_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

endpackage

// File: rtl/ipd_sequencer_tick.sv
// Free-running sample period counter with a one-cycle tick.
// Synchronous active-low reset; clear forces the count back to zero.
module tick_gen #(
    parameter int PERIOD = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    // Count 0..PERIOD-1 and wrap; clear restarts the period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/ipd_sequencer.sv
// Sample sequencer for the I-PD position loop: tick, ADC, error, enables.
// Optional ADC conversion watchdog enabled by defining ADC_TIMEOUT_EN.
module ipd_sequencer
    import ipd_sequencer_pkg::*;
#(
    parameter int N           = IPD_N,
    parameter int PERIOD      = 50000,
    parameter int ADC_TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic signed [N-1:0] setpoint,
    input  logic                adc_done,
    input  logic signed [N-1:0] adc_data,
    output logic                adc_start,
    output logic signed [N-1:0] error_out,
    output logic                integ_enable,
    output logic                pd_enable,
    output logic                sample_valid,
    output logic                busy,
    output logic                timeout_err
);

    localparam int W = N + 1;
    localparam logic signed [W-1:0] SAT_HI = W'(sat_max(N));
    localparam logic signed [W-1:0] SAT_LO = W'(sat_min(N));

    if (PERIOD < 8 || PERIOD > (1 << 20) || ADC_TIMEOUT < 1) begin : g_cfg_bad
        $error("ipd_sequencer: PERIOD or ADC_TIMEOUT out of range");
    end

    ipd_state_t state;
    ipd_state_t state_nx;

    logic tick;
    logic cnt_clr;
    logic pending;
    logic pending_nx;
    logic timed_out;

    logic signed [N-1:0] adc_q;
    logic signed [W-1:0] sp_x;
    logic signed [W-1:0] ad_x;
    logic signed [W-1:0] diff;
    logic signed [N-1:0] err_sat;

    // The period restarts from zero whenever the sequencer is parked.
    assign cnt_clr = (state == ST_IDLE);

    tick_gen #(
        .PERIOD(PERIOD)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clr),
        .tick (tick)
    );

`ifdef ADC_TIMEOUT_EN
    localparam int TW = $clog2(ADC_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ADC_TIMEOUT - 1);

    logic [TW-1:0] to_cnt;
    logic          to_flag;

    assign timed_out = (state == ST_ADC_WAIT) && !adc_done &&
                       (to_cnt == TO_LAST);

    // Count cycles spent waiting on the converter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == ST_ADC_WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_flag <= 1'b0;
        end else if (timed_out) begin
            to_flag <= 1'b1;
        end
    end

    assign timeout_err = to_flag;
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Hold the conversion result; strobes outside ADC_WAIT are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            adc_q <= '0;
        end else if ((state == ST_ADC_WAIT) && adc_done) begin
            adc_q <= adc_data;
        end
    end

    assign sp_x = {setpoint[N-1], setpoint};
    assign ad_x = {adc_q[N-1], adc_q};
    assign diff = sp_x - ad_x;

    // Clamp the widened difference back into the N-bit signed range.
    always_comb begin
        err_sat = diff[N-1:0];
        if (diff > SAT_HI) begin
            err_sat = SAT_HI[N-1:0];
        end else if (diff < SAT_LO) begin
            err_sat = SAT_LO[N-1:0];
        end
    end

    // Error register only moves in CAPTURE and holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            error_out <= '0;
        end else if (state == ST_CAPTURE) begin
            error_out <= err_sat;
        end
    end

    // Conversion request is a clean flop output, one cycle per ADC_REQ.
    always_ff @(posedge clk) begin
        if (!reset) begin
            adc_start <= 1'b0;
        end else begin
            adc_start <= (state == ST_ADC_REQ);
        end
    end

    // One-deep memory of a tick that lands while a sample is in flight.
    always_comb begin
        pending_nx = pending;
        if (state == ST_DONE) begin
            pending_nx = 1'b0;
        end else if (busy && tick) begin
            pending_nx = 1'b1;
        end
    end

    // State and pending flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
        end
    end

    // Next-state and Moore outputs for the sample sequence.
    always_comb begin
        state_nx     = state;
        busy         = 1'b1;
        integ_enable = 1'b0;
        pd_enable    = 1'b0;
        sample_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (run) begin
                    state_nx = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                busy = 1'b0;
                if (!run) begin
                    state_nx = ST_IDLE;
                end else if (tick) begin
                    state_nx = ST_ADC_REQ;
                end
            end
            ST_ADC_REQ: begin
                state_nx = ST_ADC_WAIT;
            end
            ST_ADC_WAIT: begin
                if (adc_done) begin
                    state_nx = ST_CAPTURE;
                end else if (timed_out) begin
                    state_nx = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                state_nx = ST_PIPE1;
            end
            ST_PIPE1: begin
                state_nx = ST_PIPE2;
            end
            ST_PIPE2: begin
                state_nx = ST_ACCUM;
            end
            ST_ACCUM: begin
                integ_enable = 1'b1;
                pd_enable    = 1'b1;
                state_nx     = ST_DONE;
            end
            ST_DONE: begin
                sample_valid = 1'b1;
                if (!run) begin
                    state_nx = ST_IDLE;
                end else if (pending || tick) begin
                    state_nx = ST_ADC_REQ;
                end else begin
                    state_nx = ST_WAIT_TICK;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ipd_sequencer.sv
// Self-checking bench for ipd_sequencer: vector table, random samples
// against a tick-grid timing model, reset, run-drop and watchdog cases.
module tb_ipd_sequencer;

    localparam int N      = 18;
    localparam int PERIOD = 8;
    localparam int TO     = 10;
    localparam int EMAX   = (1 << (N - 1)) - 1;
    localparam int EMIN   = -(1 << (N - 1));

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                run = 1'b0;
    logic                adc_done = 1'b0;
    logic signed [N-1:0] setpoint = '0;
    logic signed [N-1:0] adc_data = '0;
    logic                adc_start;
    logic signed [N-1:0] error_out;
    logic                integ_enable;
    logic                pd_enable;
    logic                sample_valid;
    logic                busy;
    logic                timeout_err;

    int vec = 0;
    int bad = 0;
    int cyc = 0;
    int st_cnt = 0;
    int ig_cnt = 0;
    int sv_cnt = 0;

    int tgrid = 0;
    int exp_s = 0;
    int prev_err = 0;
    bit drop_run = 1'b0;

    typedef struct {
        int sp;
        int ad;
        int dly;
        int exp;
    } vec_t;

    vec_t tbl[12];

    ipd_sequencer #(
        .N(N),
        .PERIOD(PERIOD),
        .ADC_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .setpoint(setpoint),
        .adc_done(adc_done),
        .adc_data(adc_data),
        .adc_start(adc_start),
        .error_out(error_out),
        .integ_enable(integ_enable),
        .pd_enable(pd_enable),
        .sample_valid(sample_valid),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (adc_start) st_cnt++;
        if (integ_enable) ig_cnt++;
        if (sample_valid) sv_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int sat_ref(input int sp, input int ad);
        int d;
        d = sp - ad;
        if (d > EMAX) return EMAX;
        if (d < EMIN) return EMIN;
        return d;
    endfunction

    // Ticks lie on a fixed grid; one landing between ADC_REQ and DONE
    // (inclusive) restarts the ADC two cycles after DONE, else the
    // next grid tick does; any extra ticks in that window are lost.
    function automatic int next_start(input int a, input int done_c);
        int tn;
        tn = tgrid;
        while (tn < a) tn += PERIOD;
        return (tn <= done_c) ? done_c + 2 : tn + 2;
    endfunction

    task automatic restart_model(input int r);
        tgrid = r + PERIOD;
        exp_s = r + PERIOD + 2;
    endtask

    task automatic wait_start(output int s);
        int n;
        n = 0;
        while (!adc_start && n < 64) begin
            step();
            n++;
        end
        chk("start_seen", int'(adc_start), 1);
        s = cyc;
        chk("start_cycle", s, exp_s);
        exp_s = s;
        if (drop_run) run = 1'b0;
    endtask

    task automatic finish_sample(input int s, input int sp, input int ad,
                                 input bit stray, input int exp_err);
        int dc;
        int ig0;
        ig0 = ig_cnt;
        setpoint = N'(sp);
        adc_data = N'(ad);
        adc_done = 1'b1;
        dc = cyc;
        step();
        adc_done = 1'b0;
        adc_data = N'($urandom);
        chk("err_held", int'(error_out), prev_err);
        step();
        if (stray) begin
            adc_done = 1'b1;
            adc_data = N'($urandom);
            setpoint = N'($urandom);
        end
        step();
        adc_done = 1'b0;
        chk("en_early", int'({integ_enable, pd_enable}), 0);
        step();
        chk("en_accum", int'({integ_enable, pd_enable}), 3);
        chk("sv_early", int'(sample_valid), 0);
        step();
        chk("sv_done", int'(sample_valid), 1);
        chk("err_val", int'(error_out), exp_err);
        chk("ig_count", ig_cnt - ig0, 1);
        prev_err = exp_err;
        exp_s = next_start(s - 1, dc + 5);
    endtask

    task automatic run_sample(input int sp, input int ad, input int d,
                              input bit stray, input int exp_err);
        int s;
        wait_start(s);
        step(d);
        finish_sample(s, sp, ad, stray, exp_err);
    endtask

    function automatic int pick_word();
        int k;
        k = int'($urandom_range(0, 5));
        if (k == 0) return EMAX;
        if (k == 1) return EMIN;
        return int'($urandom_range(0, (1 << N) - 1)) + EMIN;
    endfunction

    initial begin
        int s;
        int sp;
        int ad;
        int st0;
        int sv0;
        int ig0;

        tbl[0]  = '{100, 40, 3, 60};
        tbl[1]  = '{131071, -131072, 2, 131071};
        tbl[2]  = '{-131072, 131071, 1, -131072};
        tbl[3]  = '{0, 0, 0, 0};
        tbl[4]  = '{-5, 10, 4, -15};
        tbl[5]  = '{131071, -1, 5, 131071};
        tbl[6]  = '{-131072, 1, 0, -131072};
        tbl[7]  = '{70000, -70000, 2, 131071};
        tbl[8]  = '{-1, -131072, 3, 131071};
        tbl[9]  = '{-131072, 0, 9, -131072};
        tbl[10] = '{12345, -2345, 9, 14690};
        tbl[11] = '{-20000, -30000, 6, 10000};

        reset = 1'b0;
        step(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_start", int'(adc_start), 0);
        chk("rst_integ", int'(integ_enable), 0);
        chk("rst_pd", int'(pd_enable), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_error", int'(error_out), 0);
        chk("rst_timeout", int'(timeout_err), 0);

        reset = 1'b1;
        run = 1'b1;
        restart_model(cyc);
        prev_err = 0;

        for (int i = 0; i < 12; i++) begin
            run_sample(tbl[i].sp, tbl[i].ad, tbl[i].dly, bit'(i % 2),
                       tbl[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            sp = pick_word();
            ad = pick_word();
            run_sample(sp, ad, int'($urandom_range(0, 9)),
                       bit'($urandom_range(0, 1)), sat_ref(sp, ad));
        end

        drop_run = 1'b1;
        run_sample(-300, 200, 3, 1'b0, -500);
        drop_run = 1'b0;
        step();
        chk("drop_idle", int'(busy), 0);
        st0 = st_cnt;
        step(30);
        chk("drop_nostart", st_cnt - st0, 0);
        chk("drop_still_idle", int'(busy), 0);

        run = 1'b1;
        restart_model(cyc);
        wait_start(s);
        step();
        setpoint = N'(500);
        adc_data = N'(-200);
        adc_done = 1'b1;
        step();
        adc_done = 1'b0;
        step();
        chk("pipe1_err", int'(error_out), 700);
        reset = 1'b0;
        step();
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_error", int'(error_out), 0);
        chk("mid_rst_start", int'(adc_start), 0);
        chk("mid_rst_en", int'({integ_enable, pd_enable}), 0);
        chk("mid_rst_valid", int'(sample_valid), 0);
        reset = 1'b1;
        run = 1'b0;
        step(2);

        run = 1'b1;
        restart_model(cyc);
        prev_err = 0;
        run_sample(1000, 1, 2, 1'b0, 999);
        wait_start(s);
        ig0 = ig_cnt;
        sv0 = sv_cnt;
`ifdef ADC_TIMEOUT_EN
        run = 1'b0;
        step(TO - 1);
        chk("to_before", int'(timeout_err), 0);
        chk("to_sv_before", int'(sample_valid), 0);
        step();
        chk("to_flag", int'(timeout_err), 1);
        chk("to_sv", int'(sample_valid), 1);
        chk("to_err_kept", int'(error_out), prev_err);
        chk("to_no_integ", ig_cnt - ig0, 0);
        step(5);
        chk("to_sticky", int'(timeout_err), 1);
        chk("to_idle", int'(busy), 0);
        chk("to_one_sv", sv_cnt - sv0, 1);
`else
        step(30);
        chk("hang_busy", int'(busy), 1);
        chk("hang_no_to", int'(timeout_err), 0);
        chk("hang_no_sv", sv_cnt - sv0, 0);
        run = 1'b0;
        finish_sample(s, -7, 8, 1'b1, -15);
        step();
        chk("hang_idle", int'(busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/ipd_sequencer.md
IPD_SEQUENCER -- requirements
Module: ipd_sequencer

Interface
REQ-001 Parameter N, default 18: signed data word width, matching the I-PD datapath word.
REQ-002 Parameter PERIOD, default 50000: clocks per control sample, legal range 8..2^20.
REQ-003 Parameter ADC_TIMEOUT, default 1000: clocks allowed for ADC conversion.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 run  in  1  level; 1 enables periodic sampling.
REQ-007 setpoint  in  N  signed position reference.
REQ-008 adc_done  in  1  one-cycle pulse; adc_data is valid in that cycle.
REQ-009 adc_data  in  N  signed measured position.
REQ-010 adc_start  out  1  one-cycle conversion request.
REQ-011 error_out  out  N  signed error, held stable from capture until the next capture.
REQ-012 integ_enable  out  1  one-cycle accumulator enable to the integrator.
REQ-013 pd_enable  out  1  one-cycle enable to the P/D path.
REQ-014 sample_valid  out  1  one-cycle pulse; controller output is ready for the PWM stage.
REQ-015 busy  out  1  high in every state except IDLE and WAIT_TICK.
REQ-016 timeout_err  out  1  sticky ADC timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_TICK, ADC_REQ, ADC_WAIT, CAPTURE, PIPE1, PIPE2, ACCUM, DONE.
REQ-018 IDLE->WAIT_TICK when run=1; the tick counter SHALL clear on entry to WAIT_TICK.
REQ-019 The tick counter SHALL count 0..PERIOD-1 and wrap; the tick asserts at PERIOD-1; WAIT_TICK->ADC_REQ on tick.
REQ-020 ADC_REQ SHALL assert adc_start for exactly one cycle, then go to ADC_WAIT.
REQ-021 ADC_WAIT->CAPTURE on adc_done; the same-cycle adc_data SHALL be latched.
REQ-022 CAPTURE SHALL compute error_out = setpoint - adc_data in N+1 bits, saturated to the signed N-bit range [-2^(N-1), 2^(N-1)-1].
REQ-023 PIPE1 and PIPE2 SHALL each last one cycle, covering the integrator's two internal register stages.
REQ-024 ACCUM SHALL assert integ_enable and pd_enable together for exactly one cycle.
REQ-025 DONE SHALL assert sample_valid for one cycle; the next state is WAIT_TICK if run=1, else IDLE.
REQ-026 Latency from adc_done to sample_valid SHALL be exactly 5 cycles.
REQ-027 The tick counter SHALL run free during the sequence; a tick arriving while busy SHALL be counted in a one-deep pending flag and serviced immediately from DONE; further ticks while pending are dropped.
REQ-028 Dropping run mid-sequence SHALL NOT abort the sequence; the FSM SHALL complete through DONE, then go to IDLE.
REQ-029 adc_done outside ADC_WAIT SHALL be ignored.

Reset
REQ-030 With reset=0 at a clock edge: FSM->IDLE; counter, pending flag, error_out, timeout_err->0; all pulse outputs->0.
REQ-031 Reset asserted mid-sequence SHALL override every transition in the same cycle.

Configuration
REQ-032 With ADC_TIMEOUT_EN defined: a counter runs in ADC_WAIT; reaching ADC_TIMEOUT sets timeout_err, keeps the previous error_out, skips to DONE with integ_enable and pd_enable suppressed, and still pulses sample_valid.
REQ-033 Without ADC_TIMEOUT_EN: ADC_WAIT waits indefinitely, and timeout_err is tied to 0.
REQ-034 timeout_err SHALL clear only on reset.

Structure
REQ-035 A shared package or include SHALL hold the state encodings, the default N, and the saturation limits.
REQ-036 One sub-module, tick_gen (the parameterised PERIOD counter with tick output), SHALL be instantiated inside ipd_sequencer.

Verification
REQ-037 PERIOD=8, run=1, adc_done 3 cycles after adc_start, setpoint=100, adc_data=40 -> error_out=60; integ_enable 4 cycles after adc_done; sample_valid 5 cycles after adc_done.
REQ-038 setpoint=131071, adc_data=-131072, N=18 -> error_out=131071 (saturated); setpoint=-131072, adc_data=131071 -> error_out=-131072.
REQ-039 With ADC_TIMEOUT_EN, ADC_TIMEOUT=10, no adc_done -> timeout_err=1 after 10 ADC_WAIT cycles, then one sample_valid with no integ_enable, and error_out unchanged.
REQ-040 PERIOD=8, adc_done delayed 9 cycles -> one pending tick; adc_start occurs 2 cycles after sample_valid (DONE->ADC_REQ->adc_start); a second tick during the same sequence is dropped.
REQ-041 reset=0 asserted in PIPE1 -> next cycle IDLE with all outputs 0; run=0 during ADC_WAIT -> sequence completes, then IDLE with no further adc_start.
